// File: rtl/dm_access_unit.sv
// dm_access_unit: turns MEM-stage loads/stores into word-aligned bus transactions
// with byte enables, lane replication, load extension, misalignment and timeout.
`default_nettype none

module dm_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [7:0]  tmo_cnt;
  logic        err_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;

  logic        req;
  logic        is_half;
  logic        is_byte;
  logic        is_word;
  logic        misaligned;
  logic        accept;
  logic        in_wait;
  logic        tmo_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  logic        q_half;
  logic        q_byte;
  logic        q_signed;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;

  // Request decode; the reserved encodings 101..111 fall through to word.
  always_comb begin
    req        = mem_read | mem_write;
    is_half    = (dm_type == 3'b001) || (dm_type == 3'b010);
    is_byte    = (dm_type == 3'b011) || (dm_type == 3'b100);
    is_word    = ~is_half & ~is_byte;
    misaligned = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);
    accept     = (state == S_IDLE) & req & ~misaligned;
    in_wait    = (state == S_WAIT);
    tmo_hit    = in_wait & ~bus_ack & (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    if (is_half) begin
      be_calc    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be_calc    = 4'b0001 << addr[1:0];
      wdata_calc = {4{wdata[7:0]}};
    end
  end

  // Load extraction works from the type and offset latched at accept.
  always_comb begin
    q_half   = (type_q == 3'b001) || (type_q == 3'b010);
    q_byte   = (type_q == 3'b011) || (type_q == 3'b100);
    q_signed = (type_q == 3'b001) || (type_q == 3'b011);
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    load_val = bus_rdata;
    if (q_half) begin
      load_val = {{16{q_signed & half_sel[15]}}, half_sel};
    end else if (q_byte) begin
      load_val = {{24{q_signed & byte_sel[7]}}, byte_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_WAIT;
      S_WAIT: if (bus_ack || tmo_hit) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall    = accept | in_wait;
    misalign = (state == S_IDLE) & req & misaligned;
    done     = (state == S_RESP);
    bus_err  = err_q & (state == S_RESP);
  end

  // Ack takes priority over timeout when both land in the same WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
      err_q     <= 1'b0;
      tmo_cnt   <= 8'd0;
      type_q    <= 3'b000;
      off_q     <= 2'b00;
    end else if (accept) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_write;
      bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
      bus_be    <= be_calc;
      bus_wdata <= wdata_calc;
      err_q     <= 1'b0;
      tmo_cnt   <= 8'd0;
      type_q    <= dm_type;
      off_q     <= addr[1:0];
    end else if (in_wait) begin
      if (bus_ack) begin
        bus_req <= 1'b0;
        rdata   <= bus_we ? 32'h0 : load_val;
        err_q   <= 1'b0;
      end else if (tmo_hit) begin
        bus_req <= 1'b0;
        rdata   <= 32'h0;
        err_q   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Consumes the memory-stage control produced by the instruction decoder (MemWrite, a load-enable, DMType) and turns each load/store into a word-aligned data-bus transaction.
- Handles byte-enable generation, store-data lane replication, load extraction with sign/zero extension, and misalignment detection.
- Handles a variable-latency bus handshake with timeout, and stalls the pipeline while a transaction is outstanding.
- Sits between the EX/MEM pipeline register and data memory / the system bus.

Parameters:
- TIMEOUT, 16, max WAIT cycles without bus_ack before the access is aborted (1..255).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  load in MEM stage
- mem_write  in  1  store in MEM stage (MemWrite)
- dm_type  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid when done=1
- done  out  1  one-cycle pulse: access complete
- stall  out  1  freeze PC and IF/ID/EX/MEM registers
- misalign  out  1  misaligned access rejected
- bus_err  out  1  with done: access timed out
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_W  word address, addr with [1:0]=00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  completion from memory
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Request: req = mem_read | mem_write. If both are set, treat as a write. dm_type 101..111 is treated as word.
- Misaligned when word and addr[1:0]!=0, or half/half-unsigned and addr[0]!=0.
  - In IDLE: misalign = req & misaligned (combinational).
  - No bus access and no stall occur; the pipeline advances.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on req & ~misaligned. At this edge, register bus_addr, bus_be, bus_wdata, bus_we, dm_type and addr[1:0], and set bus_req=1.
  - WAIT: bus_req=1 with all bus outputs stable. Timeout counter increments each WAIT cycle.
  - WAIT -> RESP on bus_ack: capture extended bus_rdata into rdata (writes: rdata=0), bus_req=0.
  - WAIT -> RESP when the counter reaches TIMEOUT with no ack: rdata=0, bus_err=1, bus_req=0. If ack and timeout coincide, ack wins.
  - RESP -> IDLE unconditionally. done=1 for exactly this cycle; bus_err is valid only here.
- stall = (IDLE & req & ~misaligned) | WAIT. stall=0 in RESP, so the pipeline advances at the end of RESP. The same instruction is never re-issued.
- Latency: minimum 3 cycles per access (accept, WAIT with immediate ack, RESP). Back-to-back accesses are separated by one IDLE cycle.
- bus_ack outside WAIT is ignored.
- Byte enables (a = addr[1:0]):
  - word: 1111
  - half: 0011 if a[1]=0, else 1100
  - byte: 0001 << a
- Store data:
  - word: wdata
  - half: {2{wdata[15:0]}}
  - byte: {4{wdata[7:0]}}
- Load extraction:
  - word: whole bus_rdata
  - half: bus_rdata[16*a[1] +: 16], sign- or zero-extended per dm_type
  - byte: bus_rdata[8*a +: 8], sign- or zero-extended per dm_type
- Reset (also mid-transaction):
  - Next state IDLE; counter cleared.
  - bus_req, bus_we, done, bus_err, bus_addr, bus_be, bus_wdata and rdata all 0.
  - A pending ack after reset is ignored.

Test Plan:
- lw, addr=0x104, bus_rdata=0xDEADBEEF, ack on first WAIT cycle -> bus_addr=0x104, be=1111; stall high 2 cycles; done with rdata=0xDEADBEEF in cycle 3.
- lb/lbu, addr=0x203, bus_rdata=0x80123456 -> be=1000; lb rdata=0xFFFFFF80; lbu rdata=0x00000080.
- sh, addr=0x302, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD; done with rdata=0.
- lw addr=0x101 and lh addr=0x103 -> misalign=1, stall=0, bus_req never asserted.
- lw with ack withheld, TIMEOUT=16 -> bus_req high 16 WAIT cycles, then done=1 & bus_err=1, rdata=0. Repeat with ack on cycle 16: normal completion, bus_err=0.
- rst asserted during WAIT -> next cycle bus_req=0, stall=0. A later bus_ack produces no done; the next lw completes normally.
